// File: rtl/rect_pkg.sv
// Shared types for the rectangle point generator.
// rect_state_t : walker states (idle, four outline edges, raster fill, finish)
// MODE_OUTLINE / MODE_FILL : encodings of the fill input
package rect_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TOP    = 3'd1,
    RIGHT  = 3'd2,
    BOTTOM = 3'd3,
    LEFT   = 3'd4,
    FILL   = 3'd5,
    FIN    = 3'd6
  } rect_state_t;

  localparam logic MODE_OUTLINE = 1'b0;
  localparam logic MODE_FILL    = 1'b1;

endpackage

// File: rtl/rectangle_point_gen.sv
// Streams the pixel coordinates of an axis-aligned rectangle, one point per
// valid/ready handshake, either as a clockwise outline or as a raster fill.
// Ports:
//   _clock, _reset    : clock and synchronous active-high reset
//   _start            : begin a rectangle (honoured only in IDLE)
//   s_x, s_y          : top-left origin
//   width, height     : extents in pixels
//   fill              : 0 = outline, 1 = filled
//   _ready            : consumer accepts the current point
//   _out0, _out1      : current point x / y
//   _valid            : _out0/_out1 hold a point
//   _busy             : a rectangle is in progress
//   _done             : single-cycle completion pulse
module rectangle_point_gen
  import rect_pkg::*;
#(
  parameter int COORD_W = 32
) (
  input  logic               _clock,
  input  logic               _reset,
  input  logic               _start,
  input  logic [COORD_W-1:0] s_x,
  input  logic [COORD_W-1:0] s_y,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  input  logic               fill,
  input  logic               _ready,
  output logic [COORD_W-1:0] _out0,
  output logic [COORD_W-1:0] _out1,
  output logic               _valid,
  output logic               _busy,
  output logic               _done
);

  localparam logic [COORD_W-1:0] ZERO = '0;
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] TWO  = COORD_W'(2);

  rect_state_t state_q, state_d;

  // i walks along x (edge or row), j walks along y; both are offsets from
  // the latched origin so the output is always origin + offset.
  logic [COORD_W-1:0] i_q, i_d;
  logic [COORD_W-1:0] j_q, j_d;
  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] y0_q, y0_d;
  logic [COORD_W-1:0] w_q, w_d;
  logic [COORD_W-1:0] h_q, h_d;
  logic [COORD_W-1:0] out0_q, out0_d;
  logic [COORD_W-1:0] out1_q, out1_d;
  logic               valid_q, valid_d;

  logic [COORD_W-1:0] w_m1;
  logic [COORD_W-1:0] h_m1;
  logic               hs;

  assign w_m1 = w_q - ONE;
  assign h_m1 = h_q - ONE;
  assign hs   = valid_q & _ready;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    w_d     = w_q;
    h_d     = h_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (_start) begin
          x0_d = s_x;
          y0_d = s_y;
          w_d  = width;
          h_d  = height;
          i_d  = ZERO;
          j_d  = ZERO;
          if ((width == ZERO) || (height == ZERO)) begin
            state_d = FIN;
          end else begin
            state_d = (fill == MODE_FILL) ? FILL : TOP;
            valid_d = 1'b1;
          end
        end
      end

      TOP: begin
        if (hs) begin
          if (i_q != w_m1) begin
            i_d = i_q + ONE;
          end else if (h_q != ONE) begin
            state_d = RIGHT;
            j_d     = ONE;
          end else begin
            state_d = FIN;
            valid_d = 1'b0;
          end
        end
      end

      RIGHT: begin
        if (hs) begin
          if (j_q != h_m1) begin
            j_d = j_q + ONE;
          end else if (w_q != ONE) begin
            state_d = BOTTOM;
            i_d     = w_q - TWO;
          end else begin
            // Single-column rectangle: the right edge already covered it.
            state_d = FIN;
            valid_d = 1'b0;
          end
        end
      end

      BOTTOM: begin
        if (hs) begin
          if (i_q != ZERO) begin
            i_d = i_q - ONE;
          end else if (h_q != TWO) begin
            state_d = LEFT;
            j_d     = h_q - TWO;
          end else begin
            // Two rows: the left edge has no interior pixels.
            state_d = FIN;
            valid_d = 1'b0;
          end
        end
      end

      LEFT: begin
        if (hs) begin
          if (j_q != ONE) begin
            j_d = j_q - ONE;
          end else begin
            state_d = FIN;
            valid_d = 1'b0;
          end
        end
      end

      FILL: begin
        if (hs) begin
          if (i_q != w_m1) begin
            i_d = i_q + ONE;
          end else if (j_q != h_m1) begin
            i_d = ZERO;
            j_d = j_q + ONE;
          end else begin
            state_d = FIN;
            valid_d = 1'b0;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Coordinates wrap modulo 2^COORD_W by construction.
    out0_d = x0_d + i_d;
    out1_d = y0_d + j_d;
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
    end
  end

  // Operands and counters are only meaningful while busy, so they carry no reset.
  always_ff @(posedge _clock) begin
    i_q  <= i_d;
    j_q  <= j_d;
    x0_q <= x0_d;
    y0_q <= y0_d;
    w_q  <= w_d;
    h_q  <= h_d;
  end

  assign _out0  = out0_q;
  assign _out1  = out1_q;
  assign _valid = valid_q;
  assign _busy  = (state_q != IDLE);
  assign _done  = (state_q == FIN);

endmodule

// File: tb/tb_rectangle_point_gen.sv
module tb_rectangle_point_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b1;

  logic        start = 1'b0;
  logic        fill = 1'b0;
  logic [31:0] sx = '0, sy = '0, w = '0, h = '0;
  logic [31:0] ox, oy;
  logic        vld, busy, done;

  logic        start8 = 1'b0;
  logic [7:0]  sx8 = '0, sy8 = '0, w8 = '0, h8 = '0;
  logic [7:0]  ox8, oy8;
  logic        vld8, busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int done_cnt = 0;
  int done8_cnt = 0;

  logic [63:0] exp_q[$];
  logic [15:0] exp8_q[$];
  logic [63:0] e;
  logic [15:0] e8;

  logic        stall_p = 1'b0;
  logic [31:0] hx_p = '0, hy_p = '0;

  // Hand-computed outline for x=23 y=17 w=7 h=5.
  int t1x[20] = '{23,24,25,26,27,28,29, 29,29,29,29, 28,27,26,25,24,23, 23,23,23};
  int t1y[20] = '{17,17,17,17,17,17,17, 18,19,20,21, 21,21,21,21,21,21, 20,19,18};

  always #5 clk = ~clk;

  rectangle_point_gen #(.COORD_W(32)) dut (
    ._clock(clk), ._reset(rst), ._start(start),
    .s_x(sx), .s_y(sy), .width(w), .height(h), .fill(fill),
    ._ready(ready), ._out0(ox), ._out1(oy),
    ._valid(vld), ._busy(busy), ._done(done)
  );

  rectangle_point_gen #(.COORD_W(8)) dut8 (
    ._clock(clk), ._reset(rst), ._start(start8),
    .s_x(sx8), .s_y(sy8), .width(w8), .height(h8), .fill(1'b0),
    ._ready(ready), ._out0(ox8), ._out1(oy8),
    ._valid(vld8), ._busy(busy8), ._done(done8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int x, input int y);
    exp_q.push_back({32'(x), 32'(y)});
  endtask

  task automatic push_t1(input int n);
    for (int k = 0; k < n; k++) push(t1x[k], t1y[k]);
  endtask

  // Monitor for the 32-bit instance: scoreboard pops, hold stability, done.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_p) begin
        check("hold_valid", 64'(vld), 64'd1);
        check("hold_x", 64'(ox), 64'(hx_p));
        check("hold_y", 64'(oy), 64'(hy_p));
      end
      if (vld && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_point: got (%0d,%0d), expected no point", ox, oy);
        end else begin
          e = exp_q.pop_front();
          check("point_x", 64'(ox), 64'(e[63:32]));
          check("point_y", 64'(oy), 64'(e[31:0]));
          pops++;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_no_valid", 64'(vld), 64'd0);
      end
      stall_p = vld && !ready;
      hx_p = ox;
      hy_p = oy;
    end else begin
      stall_p = 1'b0;
    end
  end

  // Monitor for the 8-bit instance used by the wrap-around vector.
  always @(negedge clk) begin
    if (!rst) begin
      if (vld8 && ready) begin
        if (exp8_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_point8: got (%0d,%0d), expected no point", ox8, oy8);
        end else begin
          e8 = exp8_q.pop_front();
          check("point8_x", 64'(ox8), 64'(e8[15:8]));
          check("point8_y", 64'(oy8), 64'(e8[7:0]));
        end
      end
      if (done8) done8_cnt++;
    end
  end

  task automatic go(input int x, input int y, input int ww, input int hh, input logic f);
    @(posedge clk); #1;
    sx = 32'(x); sy = 32'(y); w = 32'(ww); h = 32'(hh); fill = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base, input int budget);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt == base) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within %0d cycles, expected done", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt), 64'(base + 1));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_pops(input string name, input int target);
    int k = 0;
    while (pops != target && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (pops != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_pop_timeout: got %0d points, expected %0d", name, pops, target);
    end
  endtask

  initial begin
    int base;
    int p0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out0", 64'(ox), 64'd0);
    check("rst_out1", 64'(oy), 64'd0);
    check("rst_valid", 64'(vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid8", 64'(vld8), 64'd0);
    rst = 1'b0;

    // Outline 7x5, ready held high
    base = done_cnt;
    push_t1(20);
    go(23, 17, 7, 5, 1'b0);
    check("t1_first_valid", 64'(vld), 64'd1);
    check("t1_first_x", 64'(ox), 64'd23);
    check("t1_first_y", 64'(oy), 64'd17);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", base, 100);

    // Fill 3x2
    base = done_cnt;
    push(23, 17); push(24, 17); push(25, 17);
    push(23, 18); push(24, 18); push(25, 18);
    go(23, 17, 3, 2, 1'b1);
    wait_done("fill", base, 50);

    // Backpressure at point #5, plus a start while busy that must be ignored
    base = done_cnt;
    p0 = pops;
    push_t1(20);
    go(23, 17, 7, 5, 1'b0);
    wait_pops("bp", p0 + 4);
    ready = 1'b0;
    sx = 32'd100; sy = 32'd100; w = 32'd2; h = 32'd2; fill = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_held_x", 64'(ox), 64'd27);
    check("bp_held_y", 64'(oy), 64'd17);
    repeat (2) @(posedge clk);
    #1;
    ready = 1'b1;
    wait_done("bp", base, 100);

    // Zero width: no points, done right after the sampling edge
    base = done_cnt;
    go(5, 5, 0, 3, 1'b0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_valid", 64'(vld), 64'd0);
    @(posedge clk); #1;
    check("zero_done_drop", 64'(done), 64'd0);
    check("zero_busy_drop", 64'(busy), 64'd0);
    check("zero_done_cnt", 64'(done_cnt), 64'(base + 1));

    // Single column w=1 h=4
    base = done_cnt;
    push(60, 17); push(60, 18); push(60, 19); push(60, 20);
    go(60, 17, 1, 4, 1'b0);
    wait_done("col", base, 50);

    // Single row h=1 w=3
    base = done_cnt;
    push(40, 9); push(41, 9); push(42, 9);
    go(40, 9, 3, 1, 1'b0);
    wait_done("row", base, 50);

    // Wrap-around on the 8-bit instance
    base = done8_cnt;
    exp8_q.push_back({8'd254, 8'd0});
    exp8_q.push_back({8'd255, 8'd0});
    exp8_q.push_back({8'd0, 8'd0});
    exp8_q.push_back({8'd1, 8'd0});
    @(posedge clk); #1;
    sx8 = 8'd254; sy8 = 8'd0; w8 = 8'd4; h8 = 8'd1;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 30 && done8_cnt == base; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("wrap_done_once", 64'(done8_cnt), 64'(base + 1));
    check("wrap_queue_empty", 64'(exp8_q.size()), 64'd0);

    // Reset while point #10 is presented
    base = done_cnt;
    p0 = pops;
    push_t1(9);
    go(23, 17, 7, 5, 1'b0);
    wait_pops("rstmid", p0 + 9);
    check("rstmid_x10", 64'(ox), 64'd29);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rstmid_out0", 64'(ox), 64'd0);
    check("rstmid_out1", 64'(oy), 64'd0);
    check("rstmid_valid", 64'(vld), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstmid_no_done", 64'(done_cnt), 64'(base));
    check("rstmid_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rstmid_idle_valid", 64'(vld), 64'd0);

    // Clean restart after reset
    base = done_cnt;
    push_t1(20);
    go(23, 17, 7, 5, 1'b0);
    check("restart_first_x", 64'(ox), 64'd23);
    check("restart_first_y", 64'(oy), 64'd17);
    wait_done("restart", base, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
